// File: rtl/cr_fifo_wr_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cr_fifo_wr_arb                                                  |
// | Purpose  : Packet-locking round-robin write arbiter in front of a shared   |
// |            1R1W FIFO write port. One requester owns the FIFO from its      |
// |            grant until its end-of-packet beat is written.                  |
// | Ports    : clk, rst          - clock, synchronous active-high reset        |
// |            req_valid_i/eop_i/data_i, req_ready_o - per-requester beats     |
// |            fifo_wen_o, fifo_wdata_o, fifo_full_i, fifo_afull_i - FIFO side |
// |            grant_id_o, busy_o - current owner and lock status              |
// |            stat_clr_i, stat_pkt_cnt_o - per-requester packet statistics    |
// | Options  : CR_FIFO_WR_ARB_STATS_EN enables the saturating 16-bit packet    |
// |            counters; when undefined stat_pkt_cnt_o is tied to zero.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module cr_fifo_wr_arb #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 71,
  parameter int ID_W   = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ-1:0]        req_eop_i,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic                    fifo_wen_o,
  output logic [DATA_W-1:0]       fifo_wdata_o,
  input  logic                    fifo_full_i,
  input  logic                    fifo_afull_i,
  output logic [ID_W-1:0]         grant_id_o,
  output logic                    busy_o,
  input  logic                    stat_clr_i,
  output logic [N_REQ*16-1:0]     stat_pkt_cnt_o
);

  localparam logic            S_IDLE   = 1'b0;
  localparam logic            S_LOCK   = 1'b1;
  localparam logic [ID_W-1:0] LAST_RST = ID_W'(N_REQ - 1);
  localparam logic [15:0]     CNT_MAX  = 16'hFFFF;

  logic            state_q, state_d;
  logic [ID_W-1:0] grant_q, grant_d;
  logic [ID_W-1:0] last_q, last_d;
  logic [ID_W-1:0] rr_pick;
  logic            rr_found;
  logic            accept;
  logic            eop_accept;

  // Owner beat is written the same cycle it is offered; fifo_full alone
  // stalls it, so the FIFO can never be overrun.
  assign accept     = (state_q == S_LOCK) && req_valid_i[grant_q] && !fifo_full_i;
  assign eop_accept = accept && req_eop_i[grant_q];

  // Round-robin search starting one past the previous owner. The sum is
  // wrapped by subtraction so non-power-of-two N_REQ works.
  always_comb begin
    int              sum;
    logic [ID_W-1:0] idx;
    rr_pick  = '0;
    rr_found = 1'b0;
    sum      = 0;
    idx      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      sum = int'(last_q) + k;
      if (sum >= N_REQ) begin
        sum = sum - N_REQ;
      end
      idx = ID_W'(sum);
      if (!rr_found && req_valid_i[idx]) begin
        rr_pick  = idx;
        rr_found = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        // afull only gates the start of a packet; a locked packet runs on.
        if (!fifo_afull_i && rr_found) begin
          state_d = S_LOCK;
          grant_d = rr_pick;
        end
      end
      S_LOCK: begin
        if (eop_accept) begin
          state_d = S_IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready_o  = '0;
    fifo_wen_o   = accept;
    busy_o       = (state_q == S_LOCK);
    grant_id_o   = grant_q;
    fifo_wdata_o = req_data_i[DATA_W-1:0];
    if (state_q == S_LOCK) begin
      req_ready_o[grant_q] = !fifo_full_i;
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q == ID_W'(i)) begin
        fifo_wdata_o = req_data_i[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef CR_FIFO_WR_ARB_STATS_EN
  logic [N_REQ-1:0][15:0] cnt_q;

  // Clear wins over a same-cycle increment; counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst || stat_clr_i) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (eop_accept && (grant_q == ID_W'(i)) && (cnt_q[i] != CNT_MAX)) begin
          cnt_q[i] <= cnt_q[i] + 16'd1;
        end
      end
    end
  end

  assign stat_pkt_cnt_o = cnt_q;
`else
  logic unused_stat_clr;

  assign unused_stat_clr = stat_clr_i;
  assign stat_pkt_cnt_o  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cr_fifo_wr_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_cr_fifo_wr_arb                                               |
// | Purpose  : Self-checking bench for cr_fifo_wr_arb: packet-level reference  |
// |            model compared every cycle plus directed literal expectations.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_cr_fifo_wr_arb;
  localparam int N  = 4;
  localparam int DW = 71;
`ifdef CR_FIFO_WR_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    valid;
  logic [N-1:0]    eop;
  logic [N*DW-1:0] data;
  logic [N-1:0]    ready;
  logic            wen;
  logic [DW-1:0]   wdata;
  logic            full;
  logic            afull;
  logic [1:0]      grant;
  logic            busy;
  logic            clr;
  logic [N*16-1:0] stat;

  always #5 clk = ~clk;

  cr_fifo_wr_arb #(.N_REQ(N), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(valid), .req_eop_i(eop), .req_data_i(data), .req_ready_o(ready),
    .fifo_wen_o(wen), .fifo_wdata_o(wdata), .fifo_full_i(full), .fifo_afull_i(afull),
    .grant_id_o(grant), .busy_o(busy), .stat_clr_i(clr), .stat_pkt_cnt_o(stat)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Source queues: bit DW is eop, [DW-1:0] is data
  logic [DW:0] srcq [N][$];
  logic [N-1:0] hold = '0;

  // Write log taken from the DUT, checked against literal expectations
  int            wl_own [$];
  logic [DW-1:0] wl_dat [$];
  int            wl_cyc [$];
  int            cyc = 0;

  // Reference model state
  bit m_locked;
  int m_owner;
  int m_last;
  int m_cnt [N];

  // Sources drive just after the falling edge
  always @(negedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (srcq[i].size() > 0 && !hold[i]) begin
        valid[i]           = 1'b1;
        eop[i]             = srcq[i][0][DW];
        data[i*DW +: DW]   = srcq[i][0][DW-1:0];
      end else begin
        valid[i]           = 1'b0;
        eop[i]             = 1'b0;
        data[i*DW +: DW]   = DW'(32'hDEAD0000 + i);
      end
    end
  end

  // Compare process and source/log bookkeeping, mid-cycle
  always @(negedge clk) begin
    logic [N-1:0] er;
    bit           ew;
    #3;
    if (!rst) begin
      er = '0;
      if (m_locked && !full) er[m_owner] = 1'b1;
      ew = m_locked && valid[m_owner] && !full;
      check("cyc_ready", ready, er);
      check("cyc_wen", wen, ew);
      check("cyc_busy", busy, m_locked);
      check("cyc_grant", grant, m_owner);
      if (ew) check("cyc_wdata", wdata, data[m_owner*DW +: DW]);
      for (int i = 0; i < N; i++)
        check("cyc_stat", stat[i*16 +: 16], STATS ? m_cnt[i] : 0);
    end
    for (int i = 0; i < N; i++)
      if (valid[i] && ready[i]) void'(srcq[i].pop_front());
    if (wen) begin
      wl_own.push_back(int'(grant));
      wl_dat.push_back(wdata);
      wl_cyc.push_back(cyc);
    end
  end

  // Packet-level model update on the rising edge (reads only bench-driven values)
  always @(posedge clk) begin
    bit acc;
    cyc++;
    if (rst) begin
      m_locked = 1'b0;
      m_owner  = 0;
      m_last   = N - 1;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else begin
      acc = m_locked && valid[m_owner] && !full;
      if (clr) begin
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
      end else if (acc && eop[m_owner] && m_cnt[m_owner] < 65535) begin
        m_cnt[m_owner]++;
      end
      if (!m_locked) begin
        if (!afull && valid != 0) begin
          for (int k = 1; k <= N; k++) begin
            if (valid[(m_last + k) % N]) begin
              m_owner = (m_last + k) % N;
              break;
            end
          end
          m_locked = 1'b1;
        end
      end else if (acc && eop[m_owner]) begin
        m_locked = 1'b0;
        m_last   = m_owner;
      end
    end
  end

  task automatic clear_log();
    wl_own.delete();
    wl_dat.delete();
    wl_cyc.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    bit done = 1'b0;
    for (int c = 0; c < max && !done; c++) begin
      @(negedge clk);
      #4;
      if (srcq[0].size() == 0 && srcq[1].size() == 0 && srcq[2].size() == 0 &&
          srcq[3].size() == 0 && !busy) done = 1'b1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got busy after %0d cycles required idle", max);
    end
  endtask

  task automatic wait_busy(input int max);
    bit done = 1'b0;
    for (int c = 0; c < max && !done; c++) begin
      @(negedge clk);
      #4;
      if (busy) done = 1'b1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL busy_timeout: got idle after %0d cycles required busy", max);
    end
  endtask

  initial begin
    rst   = 1'b1;
    full  = 1'b0;
    afull = 1'b0;
    clr   = 1'b0;
    valid = '0;
    eop   = '0;
    data  = '0;
    repeat (3) @(negedge clk);
    #4;
    // Reset state
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", ready, 0);
    check("rst_wen", wen, 0);
    check("rst_stat", stat, 0);
    @(negedge clk);
    rst = 1'b0;

    // 3-beat packet on requester 0
    clear_log();
    srcq[0].push_back({1'b0, 71'd1});
    srcq[0].push_back({1'b0, 71'd2});
    srcq[0].push_back({1'b1, 71'd3});
    @(negedge clk);
    #4;
    check("t1_grant", grant, 0);
    check("t1_busy", busy, 1);
    wait_idle(20);
    check("t1_nwr", wl_own.size(), 3);
    for (int k = 0; k < 3 && k < wl_own.size(); k++) begin
      check("t1_data", wl_dat[k], k + 1);
      check("t1_own", wl_own[k], 0);
      if (k > 0) check("t1_back2back", wl_cyc[k] - wl_cyc[k-1], 1);
    end
    check("t1_busy_end", busy, 0);
    check("t1_stat0", stat[15:0], STATS ? 1 : 0);

    // All four requesters, single-beat packets, two each
    do_reset();
    clear_log();
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < N; i++)
        srcq[i].push_back({1'b1, 71'(i * 16 + j)});
    wait_idle(40);
    check("t2_nwr", wl_own.size(), 8);
    for (int k = 0; k < 8 && k < wl_own.size(); k++) begin
      check("t2_order", wl_own[k], k % 4);
      check("t2_data", wl_dat[k], (k % 4) * 16 + k / 4);
      if (k > 0) check("t2_spacing", wl_cyc[k] - wl_cyc[k-1], 2);
    end
    for (int i = 0; i < N; i++) check("t2_stat", stat[i*16 +: 16], STATS ? 2 : 0);

    // Requester 2, 4 beats, FIFO full during beats 2-4 of the packet
    clear_log();
    for (int b = 0; b < 4; b++) srcq[2].push_back({b == 3, 71'(32 + b)});
    wait_busy(10);
    check("t3_grant", grant, 2);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      full = 1'b1;
      #4;
      check("t3_ready_full", ready[2], 0);
      check("t3_wen_full", wen, 0);
    end
    @(negedge clk);
    full = 1'b0;
    wait_idle(20);
    check("t3_nwr", wl_own.size(), 4);
    for (int k = 0; k < 4 && k < wl_own.size(); k++) check("t3_data", wl_dat[k], 32 + k);

    // Almost-full holds off arbitration
    clear_log();
    @(negedge clk);
    afull = 1'b1;
    srcq[1].push_back({1'b1, 71'h11});
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #4;
      check("t4_busy_afull", busy, 0);
    end
    @(negedge clk);
    afull = 1'b0;
    @(negedge clk);
    #4;
    check("t4_grant", grant, 1);
    check("t4_busy", busy, 1);
    wait_idle(20);
    check("t4_nwr", wl_own.size(), 1);
    if (wl_own.size() > 0) check("t4_data", wl_dat[0], 71'h11);

    // Requester 3 bubbles mid-packet while requester 0 waits
    clear_log();
    srcq[3].push_back({1'b0, 71'h30});
    srcq[3].push_back({1'b0, 71'h31});
    srcq[3].push_back({1'b1, 71'h32});
    srcq[0].push_back({1'b1, 71'h05});
    wait_busy(10);
    check("t5_grant", grant, 3);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      hold[3] = 1'b1;
      #4;
      check("t5_grant_bubble", grant, 3);
      check("t5_wen_bubble", wen, 0);
    end
    @(negedge clk);
    hold[3] = 1'b0;
    wait_idle(30);
    check("t5_nwr", wl_own.size(), 4);
    for (int k = 0; k < 4 && k < wl_own.size(); k++) begin
      check("t5_own", wl_own[k], k < 3 ? 3 : 0);
      check("t5_data", wl_dat[k], k < 3 ? 71'h30 + 71'(k) : 71'h05);
    end

`ifdef CR_FIFO_WR_ARB_STATS_EN
    // Saturation from a preloaded counter
    @(negedge clk);
    dut.cnt_q[0] = 16'hFFFD;
    m_cnt[0]     = 65533;
    for (int j = 0; j < 3; j++) srcq[0].push_back({1'b1, 71'(j)});
    wait_idle(30);
    check("t6_sat", stat[15:0], 16'hFFFF);
`endif

    // Clear coincident with an eop acceptance
    srcq[2].push_back({1'b1, 71'h42});
    wait_busy(10);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #4;
    check("t6_clr", stat, 0);
    wait_idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
